sp_link_ctrl: RTL and testbench

//  Controls the serial-to-parallel converter output on the receive side of the PCIe physical layer.

---
 rtl/sp_link_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sp_link_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_link_ctrl.sv
// rtl/sp_link_ctrl.sv - receive-side serial-to-parallel link alignment controller
//
// Purpose:
//   Enables the serial-to-parallel converter, aligns the link on a run of
//   clean COM symbols, then forwards non-COM data bytes with a valid flag.
//   A run of consecutive errored bytes drops alignment back to SEARCH.
//
// Optional feature macro: SP_LINK_CTRL_STATS_EN
//   When defined, adds err_total / relock_cnt statistics outputs.
//
// Ports:
//   clk4f      in   byte clock, rising edge
//   reset      in   asynchronous active-high reset
//   link_en    in   link enable; low forces IDLE on the next edge
//   par_in     in   recovered byte
//   par_stb    in   par_in carries a new byte this cycle
//   sym_err    in   decode error for par_in, qualified by par_stb
//   sp_en      out  converter enable
//   active     out  link aligned and active
//   data_out   out  forwarded data byte
//   valid      out  data_out holds a fresh non-COM byte
//   state_o    out  FSM state (IDLE=0 SEARCH=1 LOCK=2 ACTIVE=3)
//   err_total  out  (stats build) errored strobes seen outside IDLE
//   relock_cnt out  (stats build) ACTIVE->SEARCH transitions

module sp_link_ctrl #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] COM_SYM    = 8'hBC,
  parameter int                LOCK_COUNT = 4,
  parameter int                LOSS_COUNT = 4
) (
  input  logic              clk4f,
  input  logic              reset,
  input  logic              link_en,
  input  logic [DATA_W-1:0] par_in,
  input  logic              par_stb,
  input  logic              sym_err,
  output logic              sp_en,
  output logic              active,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic [1:0]        state_o
`ifdef SP_LINK_CTRL_STATS_EN
  ,
  output logic [15:0]       err_total,
  output logic [7:0]        relock_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCK   = 2'd2,
    ACTIVE = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  state_t     state;
  logic [3:0] com_cnt;
  logic [3:0] err_cnt;

  // Strobe qualification: an error wins over a COM match, so an errored
  // COM is never treated as clean.
  logic       is_com;
  logic       clean_stb;
  logic       err_stb;
  logic       clean_com;
  logic [4:0] com_inc;
  logic [4:0] err_inc;
  logic       lock_hit;
  logic       loss_hit;

  always_comb begin
    is_com    = (par_in == COM_SYM);
    clean_stb = par_stb & ~sym_err;
    err_stb   = par_stb & sym_err;
    clean_com = clean_stb & is_com;
    // One extra bit so the reach test never wraps at 15.
    com_inc   = {1'b0, com_cnt} + 5'd1;
    err_inc   = {1'b0, err_cnt} + 5'd1;
    lock_hit  = (com_inc >= {1'b0, LOCK_N});
    loss_hit  = link_en & (state == ACTIVE) & err_stb &
                (err_inc >= {1'b0, LOSS_N});
  end

  assign state_o = state;

  always_ff @(posedge clk4f or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      com_cnt  <= 4'd0;
      err_cnt  <= 4'd0;
      sp_en    <= 1'b0;
      active   <= 1'b0;
      valid    <= 1'b0;
      data_out <= '0;
    end else begin
      // valid is a one-cycle pulse per forwarded byte.
      valid <= 1'b0;
      if (!link_en) begin
        // Disable overrides every other transition; data_out is kept.
        state   <= IDLE;
        com_cnt <= 4'd0;
        err_cnt <= 4'd0;
        sp_en   <= 1'b0;
        active  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= SEARCH;
            sp_en <= 1'b1;
          end

          SEARCH: begin
            if (clean_com) begin
              com_cnt <= 4'd1;
              if (LOCK_N == 4'd1) begin
                state   <= ACTIVE;
                active  <= 1'b1;
                err_cnt <= 4'd0;
              end else begin
                state <= LOCK;
              end
            end
          end

          LOCK: begin
            if (par_stb) begin
              if (clean_com) begin
                com_cnt <= com_inc[4] ? 4'hF : com_inc[3:0];
                if (lock_hit) begin
                  state   <= ACTIVE;
                  active  <= 1'b1;
                  err_cnt <= 4'd0;
                end
              end else begin
                // Anything but a clean COM breaks the run.
                com_cnt <= 4'd0;
                state   <= SEARCH;
              end
            end
          end

          ACTIVE: begin
            if (err_stb) begin
              err_cnt <= err_inc[4] ? 4'hF : err_inc[3:0];
              if (loss_hit) begin
                state   <= SEARCH;
                active  <= 1'b0;
                com_cnt <= 4'd0;
                err_cnt <= 4'd0;
              end
            end else if (clean_stb) begin
              err_cnt <= 4'd0;
              // COM is idle fill: no valid, data_out keeps its value.
              if (!is_com) begin
                data_out <= par_in;
                valid    <= 1'b1;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef SP_LINK_CTRL_STATS_EN
  // Statistics survive link_en drops; only reset clears them.
  always_ff @(posedge clk4f or posedge reset) begin
    if (reset) begin
      err_total  <= 16'd0;
      relock_cnt <= 8'd0;
    end else begin
      if ((state != IDLE) && err_stb && (err_total != 16'hFFFF)) begin
        err_total <= err_total + 16'd1;
      end
      if (loss_hit && (relock_cnt != 8'hFF)) begin
        relock_cnt <= relock_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sp_link_ctrl.sv
// tb/tb_sp_link_ctrl.sv - self-checking bench for sp_link_ctrl

module tb_sp_link_ctrl;

  localparam int LOCKN = 4;
  localparam int LOSSN = 4;
  localparam int T4_LAST = 17;

  logic       clk4f = 1'b0;
  logic       reset = 1'b1;
  logic       link_en = 1'b0;
  logic [7:0] par_in = 8'h00;
  logic       par_stb = 1'b0;
  logic       sym_err = 1'b0;
  logic       sp_en;
  logic       active;
  logic [7:0] data_out;
  logic       valid;
  logic [1:0] state_o;
`ifdef SP_LINK_CTRL_STATS_EN
  logic [15:0] err_total;
  logic [7:0]  relock_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk4f = ~clk4f;

  sp_link_ctrl #(
    .DATA_W(8), .COM_SYM(8'hBC), .LOCK_COUNT(LOCKN), .LOSS_COUNT(LOSSN)
  ) dut (
    .clk4f(clk4f), .reset(reset), .link_en(link_en), .par_in(par_in),
    .par_stb(par_stb), .sym_err(sym_err), .sp_en(sp_en), .active(active),
    .data_out(data_out), .valid(valid), .state_o(state_o)
`ifdef SP_LINK_CTRL_STATS_EN
    , .err_total(err_total), .relock_cnt(relock_cnt)
`endif
  );

  typedef struct {
    logic       le;
    logic       stb;
    logic [7:0] d;
    logic       err;
    logic [1:0] st;
    logic       sp;
    logic       act;
    logic       val;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic le, logic stb, logic [7:0] d, logic err,
                              logic [1:0] st, logic sp, logic act, logic val,
                              logic [7:0] dout);
    vec_t v;
    v.le = le; v.stb = stb; v.d = d; v.err = err;
    v.st = st; v.sp = sp; v.act = act; v.val = val; v.dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] st, input logic sp,
                          input logic act, input logic val, input logic [7:0] dout);
    chk({tag, " state"}, 32'(state_o), 32'(st));
    chk({tag, " sp_en"}, 32'(sp_en), 32'(sp));
    chk({tag, " active"}, 32'(active), 32'(act));
    chk({tag, " valid"}, 32'(valid), 32'(val));
    chk({tag, " data_out"}, 32'(data_out), 32'(dout));
  endtask

  task automatic step(input logic le, input logic stb, input logic [7:0] d, input logic err);
    link_en = le; par_stb = stb; par_in = d; sym_err = err;
    @(posedge clk4f);
    #1;
  endtask

  // Behavioural reference: link phase plus run lengths of clean COMs and errors.
  int         m_mode;     // 0 idle, 1 search, 2 lock, 3 active
  int         m_coms;
  int         m_errs;
  logic       m_valid;
  logic [7:0] m_data;
  int         m_errt;
  int         m_relock;

  task automatic model_reset();
    m_mode = 0; m_coms = 0; m_errs = 0; m_valid = 0; m_data = 8'h00;
    m_errt = 0; m_relock = 0;
  endtask

  task automatic model_step(input logic le, input logic stb, input logic [7:0] d, input logic err);
    bit clean_com;
    clean_com = stb && !err && (d == 8'hBC);
    if (m_mode != 0 && stb && err && m_errt < 65535) m_errt++;
    m_valid = 0;
    if (!le) begin
      m_mode = 0; m_coms = 0; m_errs = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (clean_com) begin
        m_coms = 1;
        m_mode = (m_coms >= LOCKN) ? 3 : 2;
        m_errs = 0;
      end
    end else if (m_mode == 2) begin
      if (clean_com) begin
        m_coms++;
        if (m_coms >= LOCKN) begin m_mode = 3; m_errs = 0; end
      end else if (stb) begin
        m_coms = 0; m_mode = 1;
      end
    end else begin
      if (stb && err) begin
        m_errs++;
        if (m_errs >= LOSSN) begin
          m_mode = 1; m_errs = 0; m_coms = 0;
          if (m_relock < 255) m_relock++;
        end
      end else if (stb) begin
        m_errs = 0;
        if (d != 8'hBC) begin m_valid = 1; m_data = d; end
      end
    end
  endtask

  initial begin
    // Reset state (asynchronous, before any clock edge completes).
    #3;
    chk_outs("reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef SP_LINK_CTRL_STATS_EN
    chk("reset err_total", 32'(err_total), 32'd0);
    chk("reset relock_cnt", 32'(relock_cnt), 32'd0);
`endif
    #5 reset = 1'b0;

    // T1: align on 4 clean COMs, with a gap that must hold the count.
    tbl.push_back(mk(1,0,8'h00,0, 2'd1,1,0,0,8'h00));
    tbl.push_back(mk(1,1,8'hBC,0, 2'd2,1,0,0,8'h00));
    tbl.push_back(mk(1,1,8'hBC,0, 2'd2,1,0,0,8'h00));
    tbl.push_back(mk(1,0,8'h00,0, 2'd2,1,0,0,8'h00));
    tbl.push_back(mk(1,1,8'hBC,0, 2'd2,1,0,0,8'h00));
    tbl.push_back(mk(1,1,8'hBC,0, 2'd3,1,1,0,8'h00));
    // T2: data, idle COM, data.
    tbl.push_back(mk(1,1,8'hFF,0, 2'd3,1,1,1,8'hFF));
    tbl.push_back(mk(1,1,8'hBC,0, 2'd3,1,1,0,8'hFF));
    tbl.push_back(mk(1,1,8'hDD,0, 2'd3,1,1,1,8'hDD));
    tbl.push_back(mk(1,0,8'h00,0, 2'd3,1,1,0,8'hDD));
    // T4: 3 errors, 1 clean, 4 errors -> SEARCH on the 4th.
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,1,8'h12,1, 2'd3,1,1,0,8'hDD));
    tbl.push_back(mk(1,1,8'h34,0, 2'd3,1,1,1,8'h34));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,1,8'h56,1, 2'd3,1,1,0,8'h34));
    tbl.push_back(mk(1,1,8'h56,1, 2'd1,1,0,0,8'h34));
    // Errored COMs never count toward lock.
    tbl.push_back(mk(1,0,8'h00,0, 2'd1,1,0,0,8'h34));
    tbl.push_back(mk(1,1,8'hBC,1, 2'd1,1,0,0,8'h34));
    tbl.push_back(mk(1,1,8'hBC,0, 2'd2,1,0,0,8'h34));
    tbl.push_back(mk(1,1,8'hBC,1, 2'd1,1,0,0,8'h34));
    // T3: LOCK with 3 COMs, then 0x55 restarts, 4 more COMs needed.
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,1,8'hBC,0, 2'd2,1,0,0,8'h34));
    tbl.push_back(mk(1,1,8'h55,0, 2'd1,1,0,0,8'h34));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,1,8'hBC,0, 2'd2,1,0,0,8'h34));
    tbl.push_back(mk(1,1,8'hBC,0, 2'd3,1,1,0,8'h34));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].le, tbl[i].stb, tbl[i].d, tbl[i].err);
      chk_outs($sformatf("row%0d", i), tbl[i].st, tbl[i].sp, tbl[i].act, tbl[i].val, tbl[i].dout);
`ifdef SP_LINK_CTRL_STATS_EN
      if (i == T4_LAST) begin
        chk("t6 err_total", 32'(err_total), 32'd7);
        chk("t6 relock_cnt", 32'(relock_cnt), 32'd1);
      end
`endif
    end

    // T5a: link_en low with a strobe while ACTIVE.
    step(0, 1, 8'h77, 0);
    chk_outs("t5 link_en", 2'd0, 1'b0, 1'b0, 1'b0, 8'h34);
    step(1, 0, 8'h00, 0);
    chk_outs("t5 restart", 2'd1, 1'b1, 1'b0, 1'b0, 8'h34);
    for (int k = 0; k < 4; k++) step(1, 1, 8'hBC, 0);
    step(1, 1, 8'h5A, 0);
    chk_outs("t5 relocked", 2'd3, 1'b1, 1'b1, 1'b1, 8'h5A);

    // T5b: asynchronous reset mid-cycle with a strobe present.
    par_stb = 1'b1; par_in = 8'h66; sym_err = 1'b0;
    reset = 1'b1;
    #1;
    chk_outs("t5 async reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef SP_LINK_CTRL_STATS_EN
    chk("t5 reset err_total", 32'(err_total), 32'd0);
`endif
    @(negedge clk4f);
    reset = 1'b0;
    step(1, 0, 8'h00, 0);
    chk_outs("t5 after reset", 2'd1, 1'b1, 1'b0, 1'b0, 8'h00);

    // Randomized run against the reference model.
    link_en = 1'b0; par_stb = 1'b0;
    reset = 1'b1;
    @(negedge clk4f);
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic       le, stb, err;
      logic [7:0] d;
      le  = ($urandom_range(0, 99) >= 2);
      stb = ($urandom_range(0, 99) < 70);
      err = ($urandom_range(0, 99) < 15);
      d   = ($urandom_range(0, 99) < 45) ? 8'hBC : 8'($urandom);
      step(le, stb, d, err);
      model_step(le, stb, d, err);
      checks++;
      if (state_o !== 2'(m_mode) || sp_en !== (m_mode != 0) || active !== (m_mode == 3) ||
          valid !== m_valid || data_out !== m_data) begin
        errors++;
        $display("FAIL rand%0d: got st=%0d sp=%0b act=%0b val=%0b d=%0h expected st=%0d sp=%0b act=%0b val=%0b d=%0h",
                 n, state_o, sp_en, active, valid, data_out,
                 m_mode, (m_mode != 0), (m_mode == 3), m_valid, m_data);
      end
`ifdef SP_LINK_CTRL_STATS_EN
      chk($sformatf("rand%0d err_total", n), 32'(err_total), 32'(m_errt));
      chk($sformatf("rand%0d relock_cnt", n), 32'(relock_cnt), 32'(m_relock));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
